// File: rtl/gyro_integ_pkg.sv
// Shared types, widths and helpers for the gyro heading integrator.
//   state_t          : controller states (IDLE, CAL, RUN)
//   ACC_W/YAW_W/HEAD_W : accumulator, raw sample and heading widths
//   FUSION_GAIN_DEF  : default per-sample guardrail correction magnitude
//   sat17to16        : clamp a 17-bit signed value into 16-bit signed range
package gyro_integ_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CAL  = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam int unsigned ACC_W  = 27;
  localparam int unsigned YAW_W  = 16;
  localparam int unsigned HEAD_W = 12;

  localparam logic [ACC_W-1:0] FUSION_GAIN_DEF = 27'h0000100;

  // Overflow exists exactly when the two top bits disagree.
  function automatic logic [YAW_W-1:0] sat17to16(input logic [YAW_W:0] v);
    if (v[YAW_W] != v[YAW_W-1])
      return v[YAW_W] ? 16'h8000 : 16'h7FFF;
    else
      return v[YAW_W-1:0];
  endfunction

endpackage

// File: rtl/gyro_cal_avg.sv
// Zero-rate offset calibration: averages 2^CAL_LOG yaw samples.
//   clk, rst   : clock, synchronous active-high reset (clears offset)
//   clr        : restart calibration (clears running sum and count, wins over vld)
//   vld        : sample strobe, already qualified by the controller's CAL state
//   yaw_rt     : signed raw yaw rate
//   offset     : signed average, floor of sum / 2^CAL_LOG
//   avg_done   : registered one-cycle pulse after the final sample
//   last_smpl  : combinational, high on the vld that completes the window
module gyro_cal_avg
  import gyro_integ_pkg::*;
#(
  parameter int unsigned CAL_LOG = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             vld,
  input  logic [YAW_W-1:0] yaw_rt,
  output logic [YAW_W-1:0] offset,
  output logic             avg_done,
  output logic             last_smpl
);

  localparam int unsigned SUM_W = CAL_LOG + YAW_W;

  logic [SUM_W-1:0]   cal_acc;
  logic [SUM_W-1:0]   sum_nxt;
  logic [CAL_LOG-1:0] smpl_cnt;

  always_comb begin
    sum_nxt = cal_acc + {{CAL_LOG{yaw_rt[YAW_W-1]}}, yaw_rt};
  end

  // Exposed combinationally so the controller can leave CAL on the same edge
  // that absorbs the final sample.
  assign last_smpl = vld && !clr && (smpl_cnt == '1);

  always_ff @(posedge clk) begin
    if (rst) begin
      cal_acc  <= '0;
      smpl_cnt <= '0;
      offset   <= '0;
      avg_done <= 1'b0;
    end else begin
      avg_done <= 1'b0;
      if (clr) begin
        cal_acc  <= '0;
        smpl_cnt <= '0;
      end else if (vld) begin
        smpl_cnt <= smpl_cnt + 1'b1;
        if (smpl_cnt == '1) begin
          // Taking the upper bits is an arithmetic shift right by CAL_LOG.
          offset   <= sum_nxt[SUM_W-1:CAL_LOG];
          avg_done <= 1'b1;
          cal_acc  <= '0;
        end else begin
          cal_acc <= sum_nxt;
        end
      end
    end
  end

endmodule

// File: rtl/gyro_heading_integ.sv
// Gyro heading integrator: calibrates the zero-rate offset, integrates the
// offset-corrected yaw rate into a wrapping 12-bit heading while moving, and
// nudges it with a guardrail-IR fusion term.
//   clk, rst        : clock, synchronous active-high reset
//   strt_cal        : (re)start calibration, clears the heading
//   vld, yaw_rt     : sample strobe and signed raw yaw rate
//   moving          : integrate only while high
//   lftIR, rghtIR   : guardrail sensors driving the fusion correction
//   cal_done        : one-cycle pulse when calibration completes
//   rdy             : one-cycle pulse, heading updated for a RUN sample
//   heading         : acc[26:15], signed, wraps at +/-180 degrees
module gyro_heading_integ
  import gyro_integ_pkg::*;
#(
  parameter bit               FAST_SIM    = 1'b1,
  parameter int unsigned      CAL_LOG     = FAST_SIM ? 8 : 11,
  parameter logic [ACC_W-1:0] FUSION_GAIN = FUSION_GAIN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              strt_cal,
  input  logic              vld,
  input  logic [YAW_W-1:0]  yaw_rt,
  input  logic              moving,
  input  logic              lftIR,
  input  logic              rghtIR,
  output logic              cal_done,
  output logic              rdy,
  output logic [HEAD_W-1:0] heading
);

  state_t           state, state_nxt;
  logic             cal_vld, run_vld;
  logic             last_smpl;
  logic             avg_done;
  logic [YAW_W-1:0] offset;
  logic [YAW_W:0]   yaw_diff;
  logic [YAW_W-1:0] yaw_comp;
  logic [ACC_W-1:0] fus;
  logic [ACC_W-1:0] acc, acc_nxt;
  logic             rdy_q;

  gyro_cal_avg #(
    .CAL_LOG (CAL_LOG)
  ) u_cal (
    .clk       (clk),
    .rst       (rst),
    .clr       (strt_cal),
    .vld       (cal_vld),
    .yaw_rt    (yaw_rt),
    .offset    (offset),
    .avg_done  (avg_done),
    .last_smpl (last_smpl)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (strt_cal) begin
      state_nxt = CAL;
    end else begin
      case (state)
        CAL:     if (last_smpl) state_nxt = RUN;
        default: state_nxt = state;
      endcase
    end
  end

  // strt_cal discards any coincident sample.
  always_comb begin
    cal_vld = vld && !strt_cal && (state == CAL);
    run_vld = vld && !strt_cal && (state == RUN);
  end

  always_comb begin
    yaw_diff = {yaw_rt[YAW_W-1], yaw_rt} - {offset[YAW_W-1], offset};
    yaw_comp = sat17to16(yaw_diff);
    if (lftIR && !rghtIR)      fus = '0 - FUSION_GAIN;
    else if (rghtIR && !lftIR) fus = FUSION_GAIN;
    else                       fus = '0;
    acc_nxt = acc + {{(ACC_W-YAW_W){yaw_comp[YAW_W-1]}}, yaw_comp} + fus;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc   <= '0;
      rdy_q <= 1'b0;
    end else begin
      rdy_q <= run_vld;
      if (strt_cal)
        acc <= '0;
      else if (run_vld && moving)
        acc <= acc_nxt;
    end
  end

  assign rdy      = rdy_q;
  assign cal_done = avg_done;
  assign heading  = acc[ACC_W-1:ACC_W-HEAD_W];

endmodule
